// File: rtl/segment_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : timer_pkg
// Brief   : Shared state encoding and default sizing for the segment timer.
// Revision: 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam int TIMER_WIDTH    = 19;
    localparam int TIMER_PRESCALE = 50000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

endpackage
`default_nettype wire

// File: rtl/segment_timer_if.sv
`default_nettype none
// ============================================================================
// Module  : segment_timer_if
// Brief   : Load/hold request and expiry/progress status bundle of the timer.
// Revision: 1.0 - initial release
// ============================================================================
interface segment_timer_if
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
);
    logic             load;
    logic [WIDTH-1:0] tin;
    logic             hold;
    logic             expired;
    logic             busy;
    logic [WIDTH-1:0] remaining;

    modport master (output load, tin, hold, input expired, busy, remaining);
    modport slave  (input load, tin, hold, output expired, busy, remaining);
endinterface
`default_nettype wire

// File: rtl/segment_timer_tick.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Brief   : Free-running 0..PRESCALE-1 counter; tick marks the terminal count.
// Revision: 1.0 - initial release
// ============================================================================
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE = TIMER_PRESCALE
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      tick
);
    localparam int                 c_cnt_w = $clog2(PRESCALE);
    localparam logic [c_cnt_w-1:0] c_max   = c_cnt_w'(PRESCALE - 1);

    logic [c_cnt_w-1:0] r_count;

    // A disabled counter holds its value, so a pause resumes exactly where it left off.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == c_max) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign tick = enable && (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/segment_timer.sv
`default_nettype none
// ============================================================================
// Module  : segment_timer
// Brief   : Segment countdown FSM; SEGMENT_TIMER_RELOAD_EN enables auto-reload.
// Revision: 1.0 - initial release
// ============================================================================
module segment_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = TIMER_WIDTH,
    parameter int PRESCALE = TIMER_PRESCALE
) (
    input wire logic        clk,
    input wire logic        rst,
    segment_timer_if.slave  bus
);
    localparam logic [1:0] c_st_idle  = ST_IDLE;
    localparam logic [1:0] c_st_run   = ST_RUN;
    localparam logic [1:0] c_st_pause = ST_PAUSE;
    localparam logic [1:0] c_st_done  = ST_DONE;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] w_remaining_nx;
    logic             w_active;
    logic             w_presc_en;
    logic             w_presc_clr;
    logic             w_tick;
    logic             w_reload_go;
    logic [WIDTH-1:0] w_reload_val;

    assign w_active    = (r_state == c_st_run) || (r_state == c_st_pause);
    // load and hold both suppress counting; a suppressed tick never fires.
    assign w_presc_en  = w_active && !bus.load && !bus.hold;
    assign w_presc_clr = bus.load || w_reload_go;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_presc_clr),
        .enable (w_presc_en),
        .tick   (w_tick)
    );

`ifdef SEGMENT_TIMER_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
    logic             r_reload_arm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reload     <= '0;
            r_reload_arm <= 1'b0;
        end else if (bus.load) begin
            if (bus.tin != '0) begin
                r_reload     <= bus.tin;
                r_reload_arm <= 1'b1;
            end else begin
                r_reload_arm <= 1'b0;
            end
        end
    end

    assign w_reload_go  = (r_state == c_st_done) && r_reload_arm && !bus.load;
    assign w_reload_val = r_reload;
`else
    assign w_reload_go  = 1'b0;
    assign w_reload_val = '0;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_remaining_nx = r_remaining;
        if (bus.load) begin
            if (bus.tin != '0) begin
                w_state_nx     = c_st_run;
                w_remaining_nx = bus.tin;
            end else begin
                w_state_nx     = c_st_done;
                w_remaining_nx = '0;
            end
        end else begin
            case (r_state)
                c_st_run, c_st_pause: begin
                    if (bus.hold) begin
                        w_state_nx = c_st_pause;
                    end else begin
                        w_state_nx = c_st_run;
                        if (w_tick && (r_remaining != '0)) begin
                            w_remaining_nx = r_remaining - 1'b1;
                            if (r_remaining == WIDTH'(1)) begin
                                w_state_nx = c_st_done;
                            end
                        end
                    end
                end
                c_st_done: begin
                    if (w_reload_go) begin
                        w_state_nx     = c_st_run;
                        w_remaining_nx = w_reload_val;
                    end else begin
                        w_state_nx     = c_st_idle;
                    end
                end
                c_st_idle: w_state_nx = c_st_idle;
                default:   w_state_nx = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_remaining <= w_remaining_nx;
        end
    end

    assign bus.expired   = (r_state == c_st_done);
    assign bus.busy      = w_active;
    assign bus.remaining = r_remaining;

endmodule
`default_nettype wire
